tlb_miss_walker: RTL and testbench

- Services TLB misses in User mode: walks a single-level page table in memory and returns the translation as a new-entry pulse to the TLB.
- Sits between the TLB's miss output / new-entry input and a memory read port arbitrated with the data cache.
- Handles one walk at a time.
- Reports invalid PTEs as page faults instead of filling.

---
 rtl/tlb_miss_walker.sv | 122 ++++++++++++
 tb/tb_tlb_miss_walker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_miss_walker.sv
// ============================================================================
// Module   : tlb_miss_walker
// Brief    : Single-level page-table walker servicing TLB misses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlb_miss_walker #(
    parameter int VA_WIDTH    = 32,
    parameter int PA_WIDTH    = 20,
    parameter int PAGE_OFFSET = 12,
    parameter int PTE_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 miss_valid,
    input  logic [VA_WIDTH-1:0]  miss_virt_addr,
    output logic                 miss_ready,
    input  logic [PA_WIDTH-1:0]  ptbr,
    input  logic                 flush,
    output logic                 mem_req_valid,
    output logic [PA_WIDTH-1:0]  mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [PTE_WIDTH-1:0] mem_rsp_data,
    output logic                 new_tlb_entry,
    output logic [VA_WIDTH-1:0]  new_tlb_virt_addr,
    output logic [PA_WIDTH-1:0]  new_tlb_phy_addr,
    output logic                 new_tlb_write_priv,
    output logic                 page_fault,
    output logic [VA_WIDTH-1:0]  fault_virt_addr,
    output logic                 busy
);

    localparam int PPN_W = PA_WIDTH - PAGE_OFFSET;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]          state;
    logic [VA_WIDTH-1:0] va_q;
    logic [PA_WIDTH-1:0] pte_addr;
    logic [PA_WIDTH-1:0] phy_q;
    logic                wpriv_q;
    logic [VA_WIDTH-1:0] fault_va_q;
    logic [PA_WIDTH-1:0] vpn_offset;
    logic                pte_unused;

    // PTE index scaled by 4 bytes; the cast truncates so the add wraps modulo 2^PA_WIDTH
    assign vpn_offset = PA_WIDTH'({miss_virt_addr[VA_WIDTH-1:PAGE_OFFSET], 2'b00});
    assign pte_unused = ^mem_rsp_data[PTE_WIDTH-1:PPN_W+2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            va_q       <= '0;
            pte_addr   <= '0;
            phy_q      <= '0;
            wpriv_q    <= 1'b0;
            fault_va_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_valid && !flush) begin
                        va_q     <= miss_virt_addr;
                        pte_addr <= ptbr + vpn_offset;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // A response coinciding with flush is already consumed; nothing left to drain
                        state <= mem_rsp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_rsp_valid) begin
                        if (mem_rsp_data[0]) begin
                            phy_q   <= {mem_rsp_data[PPN_W+1:2], va_q[PAGE_OFFSET-1:0]};
                            wpriv_q <= mem_rsp_data[1];
                            state   <= S_FILL;
                        end else begin
                            fault_va_q <= va_q;
                            state      <= S_FAULT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) begin
                        state <= S_IDLE;
                    end
                end
                S_FILL:  state <= S_IDLE;
                S_FAULT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Flush withdraws the request in the same cycle so no handshake can slip through
    assign mem_req_valid      = (state == S_REQ) && !flush;
    assign mem_req_addr       = pte_addr;
    assign miss_ready         = (state == S_IDLE);
    assign busy               = (state != S_IDLE);
    assign new_tlb_entry      = (state == S_FILL);
    assign page_fault         = (state == S_FAULT);
    assign new_tlb_virt_addr  = va_q;
    assign new_tlb_phy_addr   = phy_q;
    assign new_tlb_write_priv = wpriv_q;
    assign fault_virt_addr    = fault_va_q;

endmodule

`default_nettype wire

// File: tb/tb_tlb_miss_walker.sv
// ============================================================================
// Module   : tb_tlb_miss_walker
// Brief    : Directed plus randomized bench for tlb_miss_walker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_miss_walker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_virt_addr = '0;
    logic        miss_ready;
    logic [19:0] ptbr = '0;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [19:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        new_tlb_entry;
    logic [31:0] new_tlb_virt_addr;
    logic [19:0] new_tlb_phy_addr;
    logic        new_tlb_write_priv;
    logic        page_fault;
    logic [31:0] fault_virt_addr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int fill_cnt = 0;
    int fault_cnt = 0;
    logic [31:0] model_fault_va = '0;

    tlb_miss_walker dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_virt_addr(miss_virt_addr), .miss_ready(miss_ready),
        .ptbr(ptbr), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .new_tlb_entry(new_tlb_entry), .new_tlb_virt_addr(new_tlb_virt_addr),
        .new_tlb_phy_addr(new_tlb_phy_addr), .new_tlb_write_priv(new_tlb_write_priv),
        .page_fault(page_fault), .fault_virt_addr(fault_virt_addr), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (new_tlb_entry) fill_cnt++;
        if (page_fault) fault_cnt++;
        checks++;
        assert (!(new_tlb_entry && page_fault)) else begin
            errors++;
            $error("FAIL excl obs fill=%0b fault=%0b exp not both", new_tlb_entry, page_fault);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] va, input logic [31:0] pt);
        return (pt + (va / 4096) * 4) % 32'h100000;
    endfunction

    function automatic logic [31:0] model_phy(input logic [31:0] va, input logic [31:0] pte);
        return ((pte / 4) % 256) * 4096 + (va % 4096);
    endfunction

    // Accept a miss; returns with the walker in REQ and miss withdrawn
    task automatic start_miss(input logic [31:0] va, input logic [19:0] pt);
        miss_valid = 1'b1; miss_virt_addr = va; ptbr = pt;
        step();
        miss_valid = 1'b0; ptbr = $urandom;
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_addr", {12'd0, mem_req_addr}, model_addr(va, {12'd0, pt}));
    endtask

    task automatic walk(input logic [31:0] va, input logic [19:0] pt, input logic [31:0] pte,
                        input int req_dly, input int rsp_dly);
        int f0;
        f0 = fill_cnt;
        start_miss(va, pt);
        for (int i = 0; i < req_dly; i++) begin
            step();
            chk("req_hold", {31'd0, mem_req_valid}, 32'd1);
            chk("req_stable", {12'd0, mem_req_addr}, model_addr(va, {12'd0, pt}));
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            chk("wait_busy", {31'd0, busy}, 32'd1);
            chk("wait_noreq", {31'd0, mem_req_valid}, 32'd0);
            step();
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = pte;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        chk("fill", {31'd0, new_tlb_entry}, {31'd0, pte[0]});
        chk("fault", {31'd0, page_fault}, {31'd0, ~pte[0]});
        chk("busy_end", {31'd0, busy}, 32'd1);
        if (pte[0]) begin
            chk("virt", new_tlb_virt_addr, va);
            chk("phy", {12'd0, new_tlb_phy_addr}, model_phy(va, pte));
            chk("wpriv", {31'd0, new_tlb_write_priv}, {31'd0, pte[1]});
        end else begin
            model_fault_va = va;
        end
        chk("fault_va", fault_virt_addr, model_fault_va);
        step();
        chk("pulse_end", {30'd0, new_tlb_entry, page_fault}, 32'd0);
        chk("idle", {30'd0, miss_ready, busy}, 32'd2);
        chk("fill_cnt", fill_cnt, f0 + (pte[0] ? 1 : 0));
    endtask

    initial begin
        int f0;
        int q0;
        step();
        step();
        chk("rst_ready", {31'd0, miss_ready}, 32'd1);
        chk("rst_outs", {28'd0, busy, mem_req_valid, new_tlb_entry, page_fault}, 32'd0);
        chk("rst_addr", {12'd0, mem_req_addr}, 32'd0);
        chk("rst_fva", fault_virt_addr, 32'd0);
        reset = 1'b1;
        step();

        walk(32'h0001_2345, 20'h04000, 32'h2AF, 0, 0);
        walk(32'h0001_2345, 20'h04000, 32'h2AF, 4, 5);
        walk(32'h00AB_C000, 20'h04000, 32'h2AC, 0, 1);

        // miss together with flush in IDLE is ignored
        miss_valid = 1'b1; flush = 1'b1; miss_virt_addr = 32'h7000;
        step();
        miss_valid = 1'b0; flush = 1'b0;
        chk("idle_flush", {31'd0, busy}, 32'd0);

        // flush in REQ, even with ready high, withdraws the request
        start_miss(32'h0000_3000, 20'h01000);
        flush = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk("flush_req_valid", {31'd0, mem_req_valid}, 32'd0);
        step();
        flush = 1'b0; mem_req_ready = 1'b0;
        chk("flush_req_idle", {30'd0, miss_ready, busy}, 32'd2);
        step();
        chk("flush_req_stay", {31'd0, busy}, 32'd0);

        // flush in WAIT, response 3 cycles later is drained
        f0 = fill_cnt; q0 = fault_cnt;
        start_miss(32'h0000_8000, 20'h02000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_busy", {31'd0, busy}, 32'd1);
            step();
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2AF;
        step();
        mem_rsp_valid = 1'b0;
        chk("drain_idle", {31'd0, busy}, 32'd0);
        step();
        chk("drain_nofill", fill_cnt + fault_cnt, f0 + q0);
        walk(32'h0000_1000, 20'h04000, 32'h3F7, 0, 2);

        // flush and response in the same cycle
        f0 = fill_cnt;
        start_miss(32'h0000_9000, 20'h02000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2AF;
        step();
        flush = 1'b0; mem_rsp_valid = 1'b0;
        chk("flush_rsp_idle", {31'd0, busy}, 32'd0);
        step();
        chk("flush_rsp_nofill", fill_cnt, f0);

        walk(32'h0000_5000, 20'hFFFF0, 32'h001, 0, 0);

        // asynchronous reset while in WAIT
        f0 = fill_cnt; q0 = fault_cnt;
        start_miss(32'h0004_4000, 20'h00100);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", {31'd0, miss_ready}, 32'd1);
        chk("arst_outs", {28'd0, busy, mem_req_valid, new_tlb_entry, page_fault}, 32'd0);
        chk("arst_addr", {12'd0, mem_req_addr}, 32'd0);
        chk("arst_fva", fault_virt_addr, 32'd0);
        chk("arst_virt", new_tlb_virt_addr, 32'd0);
        model_fault_va = '0;
        step();
        reset = 1'b1;
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2AE;
        step();
        mem_rsp_valid = 1'b0;
        chk("arst_rsp_ignored", {31'd0, busy}, 32'd0);
        step();
        chk("arst_nofill", fill_cnt + fault_cnt, f0 + q0);

        for (int n = 0; n < 24; n++) begin
            walk($urandom, 20'($urandom), $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
